// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arb_pkg
//  Description : Shared types, default parameters and helpers for the
//                cache FIFO write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_arb_pkg;

    // Default build parameters for the arbiter
    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 32;
    localparam int DEF_MAX_BURST = 8;

    // Arbiter state encoding: free to arbitrate, or held by a burst owner
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } arb_state_t;

    // Ceiling log2 usable in constant expressions (clog2(1) = 0)
    function automatic int clog2(input int value);
        int r_bits;
        int r_rem;
        r_bits = 0;
        r_rem  = value - 1;
        while (r_rem > 0) begin
            r_bits = r_bits + 1;
            r_rem  = r_rem >> 1;
        end
        return r_bits;
    endfunction

endpackage : cache_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational N-way round-robin picker. Returns the first
//                asserted request found scanning from i_ptr upward, modulo
//                N_REQ. When nothing is requested o_idx echoes i_ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import cache_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int ID_WIDTH = clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0]    i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic                o_any,
    output logic [ID_WIDTH-1:0] o_idx
);

    // Scan farthest-to-nearest so the closest request to i_ptr is the last
    // assignment and therefore the one that sticks
    always_comb begin
        int w_cand;
        o_any  = 1'b0;
        o_idx  = i_ptr;
        w_cand = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = (int'(i_ptr) + k) % N_REQ;
            if (i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = ID_WIDTH'(w_cand);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one cache FIFO write port among
//                N_REQ requesters. A multi-beat burst keeps the port until
//                its LAST beat or until MAX_BURST beats have been written,
//                so a cache line is never interleaved. Zero-latency: an
//                accepted beat is written into the FIFO on the same edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import cache_arb_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int ID_WIDTH  = clog2(N_REQ),
    localparam int CNT_WIDTH = clog2(MAX_BURST + 1)
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [N_REQ-1:0]          REQ_VALID,
    input  logic [N_REQ-1:0]          REQ_LAST,
    input  logic [N_REQ*WIDTH-1:0]    REQ_DATA,
    output logic [N_REQ-1:0]          REQ_READY,
    input  logic                      FIFO_FULL,
    output logic                      FIFO_WR_ENB,
    output logic [ID_WIDTH+WIDTH-1:0] FIFO_DATA,
    output logic [ID_WIDTH-1:0]       GRANT_ID,
    output logic                      LOCKED,
    output logic                      BURST_OVF
);

    localparam logic [ID_WIDTH-1:0]  c_last_id   = ID_WIDTH'(N_REQ - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_limit = CNT_WIDTH'(MAX_BURST - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one   = CNT_WIDTH'(1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [ID_WIDTH-1:0]  r_owner;
    logic [ID_WIDTH-1:0]  w_owner_nxt;
    logic [ID_WIDTH-1:0]  r_rr_ptr;
    logic [ID_WIDTH-1:0]  w_rr_ptr_nxt;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] w_beat_cnt_nxt;
    logic                 r_ovf;
    logic                 w_ovf_nxt;

    logic                 w_pick_any;
    logic [ID_WIDTH-1:0]  w_pick_idx;
    logic [ID_WIDTH-1:0]  w_gnt;
    logic [ID_WIDTH-1:0]  w_gnt_inc;
    logic [N_REQ-1:0]     w_ready;
    logic                 w_fire;
    logic                 w_last;
    logic [WIDTH-1:0]     w_gnt_data;
    logic [WIDTH-1:0]     w_data_arr [N_REQ];

    // Split the flat payload bus into one word per requester
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_data_arr[gi] = REQ_DATA[gi*WIDTH +: WIDTH];
        end
    endgenerate

    rr_pick #(
        .N_REQ    (N_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .i_req (REQ_VALID),
        .i_ptr (r_rr_ptr),
        .o_any (w_pick_any),
        .o_idx (w_pick_idx)
    );

    // Grant selection, FULL-gated ready and beat hand-off to the FIFO
    always_comb begin
        w_gnt   = (r_state == S_LOCKED) ? r_owner : w_pick_idx;
        w_ready = '0;
        if ((r_state == S_LOCKED || w_pick_any) && !FIFO_FULL) begin
            w_ready[w_gnt] = 1'b1;
        end
        w_fire     = REQ_VALID[w_gnt] & w_ready[w_gnt];
        w_last     = REQ_LAST[w_gnt];
        w_gnt_data = w_data_arr[w_gnt];
        // Explicit wrap keeps non-power-of-two N_REQ inside the valid ID range
        w_gnt_inc  = (w_gnt == c_last_id) ? '0 : w_gnt + 1'b1;
    end

    // Next-state logic: state only advances on an accepted beat
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        w_ovf_nxt      = 1'b0;
        if (w_fire) begin
            case (r_state)
                S_IDLE: begin
                    if (w_last) begin
                        w_rr_ptr_nxt = w_gnt_inc;
                    end else begin
                        w_state_nxt    = S_LOCKED;
                        w_owner_nxt    = w_gnt;
                        w_beat_cnt_nxt = c_cnt_one;
                    end
                end
                S_LOCKED: begin
                    if (w_last) begin
                        w_state_nxt    = S_IDLE;
                        w_rr_ptr_nxt   = w_gnt_inc;
                        w_beat_cnt_nxt = '0;
                    end else if (r_beat_cnt == c_cnt_limit) begin
                        // Over-long burst: release so others get a turn;
                        // the owner's remaining beats compete as a new burst
                        w_state_nxt    = S_IDLE;
                        w_rr_ptr_nxt   = w_gnt_inc;
                        w_beat_cnt_nxt = '0;
                        w_ovf_nxt      = 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, owner, pointer, beat count and overflow pulse registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_ovf      <= w_ovf_nxt;
        end
    end

    assign REQ_READY   = w_ready;
    assign FIFO_WR_ENB = w_fire;
    assign FIFO_DATA   = {w_gnt, w_gnt_data};
    assign GRANT_ID    = w_gnt;
    assign LOCKED      = (r_state == S_LOCKED);
    assign BURST_OVF   = r_ovf;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed bench for fifo_wr_arbiter. Expected FIFO writes
//                are queued by the stimulus; a negedge monitor pops and
//                compares each write the DUT issues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int MB  = 8;
    localparam int IDW = 2;

    logic                CLK;
    logic                RSTN;
    logic [N-1:0]        REQ_VALID;
    logic [N-1:0]        REQ_LAST;
    logic [N*W-1:0]      REQ_DATA;
    logic [N-1:0]        REQ_READY;
    logic                FIFO_FULL;
    logic                FIFO_WR_ENB;
    logic [IDW+W-1:0]    FIFO_DATA;
    logic [IDW-1:0]      GRANT_ID;
    logic                LOCKED;
    logic                BURST_OVF;

    int                  checks = 0;
    int                  errors = 0;
    logic [IDW+W-1:0]    exp_q[$];
    int                  exp_seq [N] = '{0, 0, 0, 0};
    int                  drv_seq [N] = '{0, 0, 0, 0};

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .REQ_VALID   (REQ_VALID),
        .REQ_LAST    (REQ_LAST),
        .REQ_DATA    (REQ_DATA),
        .REQ_READY   (REQ_READY),
        .FIFO_FULL   (FIFO_FULL),
        .FIFO_WR_ENB (FIFO_WR_ENB),
        .FIFO_DATA   (FIFO_DATA),
        .GRANT_ID    (GRANT_ID),
        .LOCKED      (LOCKED),
        .BURST_OVF   (BURST_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Payload of beat 'seq' from requester 'id'
    function automatic logic [W-1:0] mk(input int id, input int seq);
        return {8'(id), 8'hA5, 16'(seq)};
    endfunction

    // Each requester presents its next beat once the previous one is taken
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            if (REQ_VALID[i] && REQ_READY[i]) drv_seq[i] <= drv_seq[i] + 1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_data
            assign REQ_DATA[gi*W +: W] = mk(gi, drv_seq[gi]);
        end
    endgenerate

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the oldest expectation
    always @(negedge CLK) begin
        if (RSTN && FIFO_WR_ENB) begin
            chk("wr_while_full", 64'(FIFO_FULL), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected none (t=%0t)", FIFO_DATA, $time);
            end else begin
                chk("fifo_data", 64'(FIFO_DATA), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic f);
        REQ_VALID = v;
        REQ_LAST  = l;
        FIFO_FULL = f;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expw(input int id);
        exp_q.push_back({IDW'(id), mk(id, exp_seq[id])});
        exp_seq[id]++;
    endtask

    initial begin
        RSTN = 1'b0;
        drive('0, '0, 1'b0);
        #12;
        chk("rst_locked", 64'(LOCKED), 64'd0);
        chk("rst_ovf",    64'(BURST_OVF), 64'd0);
        chk("rst_wr_enb", 64'(FIFO_WR_ENB), 64'd0);
        chk("rst_ready",  64'(REQ_READY), 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        tick();

        // All requesters single-beat: strict rotation, one write per cycle
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            chk("rr_grant", 64'(GRANT_ID), 64'(k % 4));
            chk("rr_wr_enb", 64'(FIFO_WR_ENB), 64'd1);
            expw(k % 4);
            tick();
        end

        // Req1 3-beat burst is not interleaved with waiting req2
        drive(4'b0110, 4'b0100, 1'b0);
        chk("b3_grant1", 64'(GRANT_ID), 64'd1);
        expw(1);
        tick();
        drive(4'b0110, 4'b0100, 1'b0);
        chk("b3_locked", 64'(LOCKED), 64'd1);
        chk("b3_grant2", 64'(GRANT_ID), 64'd1);
        expw(1);
        tick();
        drive(4'b0110, 4'b0110, 1'b0);
        expw(1);
        tick();
        drive(4'b0100, 4'b0100, 1'b0);
        chk("b3_unlocked", 64'(LOCKED), 64'd0);
        chk("b3_next", 64'(GRANT_ID), 64'd2);
        expw(2);
        tick();

        // FULL mid-burst stalls everything, burst then resumes
        drive(4'b0100, 4'b0000, 1'b0);
        chk("full_grant", 64'(GRANT_ID), 64'd2);
        expw(2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b1100, 4'b0000, 1'b1);
            chk("full_ready", 64'(REQ_READY), 64'd0);
            chk("full_wr_enb", 64'(FIFO_WR_ENB), 64'd0);
            chk("full_locked", 64'(LOCKED), 64'd1);
            tick();
        end
        drive(4'b1100, 4'b0000, 1'b0);
        chk("resume_ready", 64'(REQ_READY), 64'b0100);
        expw(2);
        tick();
        drive(4'b1100, 4'b0100, 1'b0);
        expw(2);
        tick();
        drive(4'b1000, 4'b1000, 1'b0);
        chk("after_full", 64'(GRANT_ID), 64'd3);
        expw(3);
        tick();

        // Req0 overlong burst: forced release after 8 beats, req3 gets a turn
        for (int b = 1; b <= 8; b++) begin
            drive(4'b1001, 4'b1000, 1'b0);
            chk("ovf_grant", 64'(GRANT_ID), 64'd0);
            chk("ovf_quiet", 64'(BURST_OVF), 64'd0);
            if (b > 1) chk("ovf_locked", 64'(LOCKED), 64'd1);
            expw(0);
            tick();
        end
        drive(4'b1001, 4'b1000, 1'b0);
        chk("ovf_pulse", 64'(BURST_OVF), 64'd1);
        chk("ovf_release", 64'(LOCKED), 64'd0);
        chk("ovf_next", 64'(GRANT_ID), 64'd3);
        expw(3);
        tick();
        drive(4'b0001, 4'b0000, 1'b0);
        chk("ovf_pulse_end", 64'(BURST_OVF), 64'd0);
        chk("ovf_rest", 64'(GRANT_ID), 64'd0);
        expw(0);
        tick();
        drive(4'b0001, 4'b0001, 1'b0);
        chk("ovf_rest_lock", 64'(LOCKED), 64'd1);
        expw(0);
        tick();

        // Pointer wrap: ptr=3 with req3 and req0 pending -> 3 then 0
        drive(4'b0100, 4'b0100, 1'b0);
        chk("wrap_setup", 64'(GRANT_ID), 64'd2);
        expw(2);
        tick();
        drive(4'b1001, 4'b1001, 1'b0);
        chk("wrap_3", 64'(GRANT_ID), 64'd3);
        expw(3);
        tick();
        drive(4'b1001, 4'b1001, 1'b0);
        chk("wrap_0", 64'(GRANT_ID), 64'd0);
        expw(0);
        tick();

        // Asynchronous reset in the middle of a burst
        drive(4'b0010, 4'b0000, 1'b0);
        chk("arst_grant", 64'(GRANT_ID), 64'd1);
        expw(1);
        tick();
        drive(4'b0000, 4'b0000, 1'b0);
        chk("arst_pre_locked", 64'(LOCKED), 64'd1);
        #1;
        RSTN = 1'b0;
        #1;
        chk("arst_locked", 64'(LOCKED), 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        tick();
        drive(4'b0011, 4'b0011, 1'b0);
        chk("arst_ptr0", 64'(GRANT_ID), 64'd0);
        expw(0);
        tick();
        drive(4'b0010, 4'b0010, 1'b0);
        chk("arst_next", 64'(GRANT_ID), 64'd1);
        expw(1);
        tick();

        drive('0, '0, 1'b0);
        tick();
        tick();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
